// File: rtl/sim_uart_rx.sv
// ---------------------------------------------------------------------------
// sim_uart_rx
//
// Receive-side UART deserializer for the car-simulator link. It recovers
// 8-bit feedback frames from the PC simulator, presents the last correctly
// framed byte on `rec`, and decodes the four detector flags from it.
//
// Optional feature macro: SIM_RX_PARITY_EN
//   defined     -> 11-bit frames (start, 8 data LSB first, even parity, stop);
//                  parity_err is live.
//   not defined -> 10-bit frames (8N1); parity_err is tied to 0.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bit/s (BIT_CNT = CLK_FREQ / BAUD clocks per bit)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   rec         out  last correctly framed byte (holds between frames)
//   rec_valid   out  one-cycle pulse when rec is updated
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on even-parity mismatch
//   detector    out  flags from rec: [0] front [1] left [2] right [3] back
//   busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module sim_uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rec,
    output logic       rec_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic [3:0] detector,
    output logic       busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    // Terminal counts: a sample is taken on the cycle the counter holds
    // these values, then the counter wraps to zero.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SIM_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    // Synchronizer
    logic             sync1_q;
    logic             rx_s_q;

    // FSM state and datapath
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       idx_q,        idx_d;
    logic [7:0]       shift_q,      shift_d;
`ifdef SIM_RX_PARITY_EN
    logic             par_bad_q,    par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Registered outputs
    logic [7:0]       rec_q,        rec_d;
    logic [3:0]       det_q,        det_d;
    logic             rec_valid_q,  rec_valid_d;
    logic             frame_err_q,  frame_err_d;
    logic             busy_q,       busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        rec_d        = rec_q;
        det_d        = det_q;
        rec_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SIM_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Half a bit in: a line that is already high again was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef SIM_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef SIM_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_d = (^shift_q) ^ rx_s_q;
                    state_d   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
`ifdef SIM_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rec_d       = shift_q;
                            det_d       = shift_q[3:0];
                            rec_valid_d = 1'b1;
                        end
`else
                        rec_d       = shift_q;
                        det_d       = shift_q[3:0];
                        rec_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Hold here until the line returns high so a stuck-low line
                // cannot look like an endless stream of start bits.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Registered so that busy tracks state_q exactly.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            rec_q        <= 8'h00;
            det_q        <= 4'b0000;
            rec_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SIM_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rx;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rec_q        <= rec_d;
            det_q        <= det_d;
            rec_valid_q  <= rec_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef SIM_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rec       = rec_q;
    assign detector  = det_q;
    assign rec_valid = rec_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef SIM_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sim_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_sim_uart_rx
//
// Scoreboard bench for sim_uart_rx at CLK_FREQ=16, BAUD=1 (16 clocks/bit).
// The stimulus side serialises bytes onto rx and pushes the expected outcome
// of each frame (good byte / framing error / parity error) into a queue; an
// independent monitor pops an entry for every output pulse and compares it.
// Compile with +define+SIM_RX_PARITY_EN to exercise the parity build.
// ---------------------------------------------------------------------------
module tb_sim_uart_rx;

    localparam int BITC = 16;
`ifdef SIM_RX_PARITY_EN
    localparam bit PAR_EN    = 1'b1;
    localparam int VALID_LAT = 2 + 8 + 10 * BITC + 1;
`else
    localparam bit PAR_EN    = 1'b0;
    localparam int VALID_LAT = 2 + 8 + 9 * BITC + 1;
`endif

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] rec;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rec;
    logic       rec_valid;
    logic       frame_err;
    logic       parity_err;
    logic [3:0] detector;
    logic       busy;

    exp_t       exp_q[$];
    logic [7:0] model_rec;
    int         tests;
    int         fails;
    int         cyc;
    int         last_valid_cyc;

    sim_uart_rx #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rec        (rec),
        .rec_valid  (rec_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .detector   (detector),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    // Serialise one frame and record what the receiver should report.
    // A bad stop bit leaves rx low on return; the caller restores the line.
    task automatic xfer(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        exp_t e;
        logic bad_par;
        logic pbit;
        bad_par = !par_ok;
        pbit    = (^b) ^ bad_par;
        if (!stop_ok) begin
            e.kind = K_FERR;
            e.rec  = model_rec;
        end else if (PAR_EN && bad_par) begin
            e.kind = K_PERR;
            e.rec  = model_rec;
        end else begin
            e.kind    = K_VALID;
            e.rec     = b;
            model_rec = b;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SIM_RX_PARITY_EN
        drive_bit(pbit);
`else
        if (pbit === 1'bx) rx = 1'b1;
`endif
        drive_bit(stop_ok);
    endtask

    // Monitor: every output pulse consumes one scoreboard entry.
    initial begin
        int   n;
        int   kind;
        exp_t e;
        last_valid_cyc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = int'(rec_valid) + int'(frame_err) + int'(parity_err);
                if (n > 1) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse_exclusive: got %0d pulses at once, expected at most 1", n);
                end else if (n == 1) begin
                    kind = rec_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
                    if (rec_valid) last_valid_cyc = cyc;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse: got kind=%0d rec=%02h, expected no pulse", kind, rec);
                    end else begin
                        e = exp_q.pop_front();
                        if (kind != e.kind || rec !== e.rec || detector !== e.rec[3:0]) begin
                            fails++;
                            $display("FAIL scoreboard: got kind=%0d rec=%02h det=%04b, expected kind=%0d rec=%02h det=%04b",
                                     kind, rec, detector, e.kind, e.rec, e.rec[3:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int start_cyc;
        int gap;
        logic [7:0] b;
        logic sok;
        logic pok;
        tests     = 0;
        fails     = 0;
        model_rec = 8'h00;
        rst       = 1'b0;
        rx        = 1'b1;

        // Reset held with rx toggling
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 rx = ~rx;
        end
        @(negedge clk);
        check("reset_rec", rec, 8'h00);
        check("reset_det", detector, 4'b0000);
        check("reset_pulses", {rec_valid, frame_err, parity_err}, 3'b000);
        check("reset_busy", busy, 1'b0);
        rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_rec", rec, 8'h00);

        // Single frame A5 with latency measurement
        start_cyc      = cyc;
        last_valid_cyc = -1;
        xfer(8'hA5, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("a5_latency", last_valid_cyc - start_cyc, VALID_LAT);
        check("a5_rec", rec, 8'hA5);
        check("a5_det", detector, 4'b0101);
        check("a5_busy", busy, 1'b0);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("glitch_busy_hi", busy, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_lo", busy, 1'b0);
        check("glitch_rec", rec, 8'hA5);

        // Stop bit held low, then line recovers
        xfer(8'h3C, 1'b0, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("break_busy", busy, 1'b1);
        check("break_rec", rec, 8'hA5);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("break_exit", busy, 1'b0);
        xfer(8'h0F, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("after_break_det", detector, 4'b1111);

        // Back-to-back frames
        xfer(8'h01, 1'b1, 1'b1);
        xfer(8'h08, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_rec", rec, 8'h08);
        check("b2b_det", detector, 4'b1000);

        // Reset in the middle of data bit 4
        b = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("midrst_outputs", {rec, detector, rec_valid, frame_err, parity_err, busy}, 16'h0000);
        model_rec = 8'h00;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_idle", {rec, busy}, 9'h000);
        xfer(8'hC6, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_next", rec, 8'hC6);

`ifdef SIM_RX_PARITY_EN
        // 07 has odd weight, so a parity bit of 0 is a mismatch
        xfer(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("parity_rec_kept", rec, 8'hC6);
`endif

        // Randomised frames, gaps, framing and parity faults
        for (int n = 0; n < 30; n++) begin
            b   = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 5) != 0);
            pok = ($urandom_range(0, 5) != 0);
            xfer(b, sok, pok);
            if (!sok) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1 rx = 1'b1;
                repeat (4) @(posedge clk);
                #1;
            end
            gap = $urandom_range(0, 12);
            repeat (gap) @(posedge clk);
            #1;
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_rec", rec, model_rec);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sim_uart_rx.md
# sim_uart_rx

Receive-side UART deserializer for the car-simulator link. It sits between the board `rx` pin and the driving-mode logic. It recovers 8-bit feedback frames sent by the PC simulator and presents the last good byte on `rec`. It also decodes the four detector flags for the driving modes. It is the counterpart of the command-byte path that drives the simulator.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived constant `BIT_CNT = CLK_FREQ / BAUD` (integer divide; 10416 at defaults). `HALF_CNT = BIT_CNT / 2`.

Ports:
- `clk`  in  1: system clock (100 MHz, P17).
- `rst`  in  1: asynchronous, active-low reset. It resets all state immediately on assertion.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `rec`  out  8: last correctly framed byte. Reset value is 8'h00.
- `rec_valid`  out  1: one-cycle pulse when `rec` is updated. Reset value is 0.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low. Reset value is 0.
- `parity_err`  out  1: one-cycle pulse on parity mismatch. Reset value is 0. Tied to 0 when the parity feature is compiled out.
- `detector`  out  4: detector flags from `rec`: [0] front, [1] left, [2] right, [3] back. Reset value is 4'b0000. Updated in the same cycle as `rec`.
- `busy`  out  1: high in any state other than IDLE. Reset value is 0.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value `rx_s`.
- The FSM has the states IDLE, START, DATA, [PARITY], STOP, BREAK.
- **IDLE**: on `rx_s` = 0, clear the baud counter and go to START.
- **START**: count to HALF_CNT-1, then sample.
  - If `rx_s` = 1, it is a false start: return to IDLE with no pulse.
  - Otherwise clear the counter and go to DATA.
- **DATA**: sample every BIT_CNT cycles (mid-bit), LSB first, into a shift register. A 3-bit index counts the bits.
  - After bit 7, go to PARITY if compiled in, else STOP.
- **PARITY** (optional): sample one bit after BIT_CNT cycles. Even parity: the XOR of the data bits and the parity bit must be 0. A mismatch sets an internal flag.
- **STOP**: sample after BIT_CNT cycles.
  - If `rx_s` = 1 and no parity flag: load `rec` and `detector`, pulse `rec_valid`, go to IDLE.
  - If `rx_s` = 1 with the parity flag set: pulse `parity_err`, leave `rec` unchanged, go to IDLE.
  - If `rx_s` = 0: pulse `frame_err`, leave `rec` unchanged, go to BREAK.
- **BREAK**: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from re-triggering.
- Baud counter width is `$clog2(BIT_CNT)`. It wraps to 0 on every sample.
- `rec` and `detector` hold their values indefinitely between valid frames.

## Timing
- Synchronizer latency is 2 cycles.
- The start-bit check falls HALF_CNT cycles after `rx_s` falls.
- Data bit n is sampled at HALF_CNT + (n+1)·BIT_CNT cycles after the `rx_s` fall.
- `rec_valid` rises 1 cycle after the stop sample. The total is 2 + HALF_CNT + 9·BIT_CNT + 1 cycles from the `rx` falling edge (no parity). With parity, add BIT_CNT.
- Back-to-back frames are supported. After a valid stop the FSM is in IDLE within half a bit and detects the next start edge.
- Reset asserted mid-frame: the FSM returns to IDLE immediately and all outputs take their reset values. The partial byte is discarded.
- Pulse outputs are mutually exclusive and last exactly one cycle.

## Configuration
- `SIM_RX_PARITY_EN` defined:
  - Frame is 11 bits: start, 8 data, even parity, stop.
  - PARITY state is present and `parity_err` is live.
- `SIM_RX_PARITY_EN` not defined:
  - Frame is 10 bits (8N1).
  - PARITY state is absent and `parity_err` is constant 0.

## Test plan
All scenarios use `CLK_FREQ`=16 and `BAUD`=1, so BIT_CNT=16 and HALF_CNT=8.
- **Reset**: hold `rst`=0 with `rx` toggling → `rec`=00, `detector`=0000, all pulses 0, `busy`=0. Release reset → stays idle while `rx`=1.
- **Single 8N1 frame 8'hA5**: `rec_valid` is a single pulse at cycle 2+8+144+1 from the start edge. Then `rec`=A5 and `detector`=0101.
- **Glitch**: `rx` low for 4 cycles → no pulse, `busy` drops back to 0, `rec` unchanged.
- **Stop bit held low with byte 8'h3C**: `frame_err` pulses once, `rec` keeps its prior value, FSM stays in BREAK until `rx` high. A following frame 8'h0F is received correctly with `detector`=1111.
- **Back-to-back 8'h01 and 8'h08**: two `rec_valid` pulses. `detector` goes to 0001, then 1000.
- **Reset mid-frame, and parity**: pulse `rst` low during data bit 4 → no pulse, outputs at reset values, next frame decodes normally. With `SIM_RX_PARITY_EN`, byte 8'h07 sent with parity bit 0 → `parity_err` pulse and `rec` unchanged.
